// File: rtl/binary_frame_writer_pkg.sv
// Shared definitions for the label frame buffer: label codes and writer state encoding.
// Also used by the zebra-crossing detector.
package binary_frame_writer_pkg;

   localparam logic [1:0] LBL_BLACK   = 2'b00;
   localparam logic [1:0] LBL_WHITE   = 2'b01;
   localparam logic [1:0] LBL_VISITED = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_HANDOFF,
      ST_WAIT_DET
   } wr_state_t;

   function automatic logic [1:0] label_code(input logic [7:0] pixel, input logic [7:0] thr);
      return (pixel >= thr) ? LBL_WHITE : LBL_BLACK;
   endfunction

endpackage

// File: rtl/binary_frame_writer_pixel_thresholder.sv
// Registered pixel threshold stage: turns one accepted beat into one label BRAM write
// on the following cycle.
module binary_frame_writer_pixel_thresholder
   import binary_frame_writer_pkg::*;
#(
   parameter int ADDR_W = 19
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [7:0]        in_pixel,
   input  logic [7:0]        threshold,
   output logic              white,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [1:0]        bram_wdata
);

   logic [1:0] code;

   assign code  = label_code(in_pixel, threshold);
   // Unregistered flag so the frame counter can include a beat in the same cycle it is accepted.
   assign white = (code == LBL_WHITE);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bram_we    <= 1'b0;
         bram_addr  <= '0;
         bram_wdata <= LBL_BLACK;
      end else begin
         bram_we <= in_valid;
         if (in_valid) begin
            bram_addr  <= in_addr;
            bram_wdata <= code;
         end
      end
   end

endmodule

// File: rtl/binary_frame_writer.sv
// Producer side of the label frame buffer: thresholds a raster pixel stream into the BRAM,
// hands each complete frame to the detector and back-pressures until it is released.
module binary_frame_writer
   import binary_frame_writer_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int ADDR_W     = $clog2(IMG_WIDTH*IMG_HEIGHT),
   parameter int CNT_W      = $clog2(IMG_WIDTH*IMG_HEIGHT+1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [7:0]        s_data,
   input  logic              s_sof,
   input  logic [7:0]        threshold,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [1:0]        bram_wdata,
   output logic              valid_to_read,
   input  logic              detection_valid,
   output logic [CNT_W-1:0]  white_count,
   output logic              frame_error
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WIDTH*IMG_HEIGHT-1);

   wr_state_t         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, wr_addr;
   logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
   logic              accept, wr_en, white, ferr_d;

   assign s_ready = (state_q == ST_IDLE) || (state_q == ST_WRITE);
   assign accept  = s_valid && s_ready;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      run_cnt_d = run_cnt_q;
      wr_en     = 1'b0;
      wr_addr   = addr_q;
      ferr_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept && s_sof) begin
               wr_en     = 1'b1;
               wr_addr   = '0;
               addr_d    = ADDR_W'(1);
               run_cnt_d = CNT_W'(white);
               state_d   = (LAST_ADDR == '0) ? ST_HANDOFF : ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (accept) begin
               wr_en = 1'b1;
               // The final pixel closes the frame even if it carries a stray sof.
               if (addr_q == LAST_ADDR) begin
                  addr_d    = '0;
                  run_cnt_d = run_cnt_q + CNT_W'(white);
                  state_d   = ST_HANDOFF;
               end else if (s_sof) begin
                  ferr_d    = 1'b1;
                  wr_addr   = '0;
                  addr_d    = ADDR_W'(1);
                  run_cnt_d = CNT_W'(white);
               end else begin
                  addr_d    = addr_q + ADDR_W'(1);
                  run_cnt_d = run_cnt_q + CNT_W'(white);
               end
            end
         end
         ST_HANDOFF:  state_d = ST_WAIT_DET;
         ST_WAIT_DET: if (detection_valid) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         run_cnt_q     <= '0;
         valid_to_read <= 1'b0;
         white_count   <= '0;
         frame_error   <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         run_cnt_q     <= run_cnt_d;
         valid_to_read <= (state_q == ST_HANDOFF);
         if (state_q == ST_HANDOFF) white_count <= run_cnt_q;
         frame_error   <= ferr_d;
      end
   end

   binary_frame_writer_pixel_thresholder #(
      .ADDR_W (ADDR_W)
   ) u_thresholder (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (wr_en),
      .in_addr    (wr_addr),
      .in_pixel   (s_data),
      .threshold  (threshold),
      .white      (white),
      .bram_we    (bram_we),
      .bram_addr  (bram_addr),
      .bram_wdata (bram_wdata)
   );

endmodule

// File: tb/tb_binary_frame_writer.sv
// Scoreboard bench for binary_frame_writer on an 8x4 frame: a per-beat frame model queues
// expected writes, handoffs and errors; a negedge monitor pops and compares them.
module tb_binary_frame_writer;

   localparam int W      = 8;
   localparam int H      = 4;
   localparam int N      = W*H;
   localparam int ADDR_W = $clog2(N);
   localparam int CNT_W  = $clog2(N+1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              s_valid;
   logic              s_ready;
   logic [7:0]        s_data;
   logic              s_sof;
   logic [7:0]        threshold;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [1:0]        bram_wdata;
   logic              valid_to_read;
   logic              detection_valid;
   logic [CNT_W-1:0]  white_count;
   logic              frame_error;

   binary_frame_writer #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .s_valid         (s_valid),
      .s_ready         (s_ready),
      .s_data          (s_data),
      .s_sof           (s_sof),
      .threshold       (threshold),
      .bram_we         (bram_we),
      .bram_addr       (bram_addr),
      .bram_wdata      (bram_wdata),
      .valid_to_read   (valid_to_read),
      .detection_valid (detection_valid),
      .white_count     (white_count),
      .frame_error     (frame_error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Frame model: what the label buffer should receive, derived from the frame rules.
   typedef struct {
      int addr;
      int code;
   } wr_t;

   wr_t wr_q[$];
   int  hand_q[$];
   int  err_q[$];
   bit  in_frame = 0;
   int  pos      = 0;
   int  wcnt     = 0;
   bit  blocked  = 0;

   function automatic void model_beat(input logic [7:0] d, input logic sof, input logic [7:0] thr);
      int code;
      code = (d >= thr) ? 1 : 0;
      if (!in_frame && !sof) return;
      if (!in_frame) begin
         in_frame = 1; pos = 0; wcnt = 0;
      end else if (sof && pos != N-1) begin
         err_q.push_back(1);
         pos = 0; wcnt = 0;
      end
      wr_q.push_back('{pos, code});
      wcnt += code;
      pos++;
      if (pos == N) begin
         hand_q.push_back(wcnt);
         in_frame = 0;
         blocked  = 1;
      end
   endfunction

   function automatic void model_reset();
      in_frame = 0; pos = 0; wcnt = 0; blocked = 0;
   endfunction

   // Monitor: compare whatever the DUT presents against the scoreboard queues.
   int cyc          = 0;
   int last_wr_cyc  = -10;
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n) begin
            if (bram_we) begin
               check("wdata_not_visited", bram_wdata != 2'b10, 1);
               check("write_expected", wr_q.size() != 0, 1);
               if (wr_q.size() != 0) begin
                  wr_t e;
                  e = wr_q.pop_front();
                  check("bram_addr", bram_addr, e.addr);
                  check("bram_wdata", bram_wdata, e.code);
                  if (e.addr == N-1) last_wr_cyc = cyc;
               end
            end
            if (valid_to_read) begin
               check("v2r_expected", hand_q.size() != 0, 1);
               if (hand_q.size() != 0) begin
                  check("v2r_one_after_last_write", cyc, last_wr_cyc + 1);
                  check("white_count", white_count, hand_q.pop_front());
               end
            end
            if (frame_error) begin
               check("frame_error_expected", err_q.size() != 0, 1);
               if (err_q.size() != 0) void'(err_q.pop_front());
               check("frame_error_with_addr0_write", bram_we && bram_addr == '0, 1);
            end
         end
      end
   end

   // One clock of stimulus; inputs change 1 time unit after the rising edge.
   task automatic tick(input logic v, input logic [7:0] d, input logic sof, input logic [7:0] thr,
                       input logic det, output bit acc);
      s_valid = v; s_data = d; s_sof = sof; threshold = thr; detection_valid = det;
      check("s_ready", s_ready, !blocked);
      acc = v && s_ready;
      @(posedge clk); #1;
      if (acc) model_beat(d, sof, thr);
      if (det && blocked) blocked = 0;
   endtask

   task automatic send(input logic [7:0] d, input logic sof, input logic [7:0] thr, input int gap_pct);
      bit acc = 0;
      bit dummy;
      int n = 0;
      while (!acc) begin
         if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct)
            tick(1'b0, 8'($urandom), 1'b0, thr, 1'b0, dummy);
         else
            tick(1'b1, d, sof, thr, 1'b0, acc);
         n++;
         if (n > 100) begin
            check("beat_accept_timeout", n, 0);
            break;
         end
      end
   endtask

   task automatic idle(input int cycles);
      bit a;
      repeat (cycles) tick(1'b0, 8'd0, 1'b0, 8'd128, 1'b0, a);
   endtask

   task automatic release_frame();
      bit a;
      idle(3);
      tick(1'b0, 8'd0, 1'b0, 8'd128, 1'b1, a);
      idle(1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_s_ready"}, s_ready, 1);
      check({tag, "_bram_we"}, bram_we, 0);
      check({tag, "_bram_addr"}, bram_addr, 0);
      check({tag, "_bram_wdata"}, bram_wdata, 0);
      check({tag, "_valid_to_read"}, valid_to_read, 0);
      check({tag, "_white_count"}, white_count, 0);
      check({tag, "_frame_error"}, frame_error, 0);
   endtask

   logic [7:0] pix [N];

   initial begin
      bit a;
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_sof = 1'b0;
      threshold = 8'd128; detection_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_reset_values("in_reset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check_reset_values("after_reset");

      // Alternating 200/50 at threshold 128, then 20 blocked cycles with s_valid high.
      for (int i = 0; i < N; i++) send((i % 2 == 0) ? 8'd200 : 8'd50, i == 0, 8'd128, 0);
      for (int i = 0; i < 20; i++) tick(1'b1, 8'($urandom), 1'($urandom), 8'd128, 1'b0, a);
      tick(1'b1, 8'd7, 1'b0, 8'd128, 1'b1, a);
      idle(1);

      // Garbage before sof, then an all-255 frame at threshold 255.
      for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0, 8'd255, 0);
      for (int i = 0; i < N; i++) send(8'd255, i == 0, 8'd255, 0);
      release_frame();

      // detection_valid outside the wait phase is ignored.
      tick(1'b0, 8'd0, 1'b0, 8'd128, 1'b1, a);

      // Mid-frame resync: 10 beats, then a fresh all-zero frame.
      for (int i = 0; i < 10; i++) send(8'($urandom), i == 0, 8'd100, 0);
      for (int i = 0; i < N; i++) send(8'd0, i == 0, 8'd100, 0);
      release_frame();

      // Same random frame without and with bubbles.
      for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
      for (int i = 0; i < N; i++) send(pix[i], i == 0, 8'd90, 0);
      release_frame();
      for (int i = 0; i < N; i++) send(pix[i], i == 0, 8'd90, 40);
      release_frame();

      // Reset at pixel 15, then a complete frame from address 0.
      for (int i = 0; i <= 15; i++) send(8'($urandom), i == 0, 8'd128, 20);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1 check_reset_values("mid_frame_reset");
      check("writes_drained_at_reset", wr_q.size(), 0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check_reset_values("post_mid_reset");
      for (int i = 0; i < N; i++) send(8'($urandom), i == 0, 8'd128, 10);
      release_frame();

      // Threshold boundary: pixel equal to or one below a per-beat threshold.
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < N; i++) begin
            logic [7:0] thr;
            thr = 8'($urandom);
            if (i < 2) thr = (f == 0) ? 8'd0 : 8'd255;
            send($urandom_range(1, 0) == 1 ? thr : thr - 8'd1, i == 0, thr, 15);
         end
         release_frame();
      end

      idle(4);
      check("final_writes_pending", wr_q.size(), 0);
      check("final_handoffs_pending", hand_q.size(), 0);
      check("final_errors_pending", err_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end

endmodule
